// File: rtl/id_stage.sv
// RV32I instruction-decode stage: 32x32 register file, decoder, ID/EX pipeline register and hazard logic.
// Build option: define ID_WB_BYPASS_EN for same-cycle writeback-to-read forwarding (otherwise a match stalls).
`timescale 1ns/1ps

package id_stage_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        alu_src_imm;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  mem_size;
      logic        reg_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } id_ex_t;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   // alu_op is {funct7[5], funct3} for OP/OP-IMM and {0, funct3} as a compare code when branch=1;
   // the two otherwise-unused codes below select the LUI and AUIPC datapaths.
   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_AUIPC = 4'hA;
   localparam logic [3:0] ALU_LUI   = 4'hE;

endpackage

module id_stage
   import id_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  if_id_t      if_id_in,
   input  logic        stall_in,
   input  logic        flush,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        stall_out,
   output id_ex_t      id_ex_out
);

   logic [31:0]       rf_q [32];
   id_ex_t            id_ex_q;
   id_ex_t            id_ex_d;
   id_ex_t            dec;

   logic [31:0]       instr;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [4:0]        rd;
   logic [1:0][4:0]   rs_addr;
   logic [1:0][31:0]  rs_val;
   logic [1:0]        rs_use;
   logic [1:0]        lu_hit;
   logic [1:0]        wb_hit;
   logic              load_use;

   logic [31:0]       imm_i;
   logic [31:0]       imm_s;
   logic [31:0]       imm_b;
   logic [31:0]       imm_u;
   logic [31:0]       imm_j;

   assign instr      = if_id_in.instr;
   assign opcode     = instr[6:0];
   assign funct3     = instr[14:12];
   assign rd         = instr[11:7];
   assign rs_addr[0] = instr[19:15];
   assign rs_addr[1] = instr[24:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // x0 is reset to zero and never written, so it reads as zero without a dedicated mux.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_we && (wb_rd != 5'd0)) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef ID_WB_BYPASS_EN
      logic fwd;
      assign fwd          = wb_we && (wb_rd != 5'd0) && (wb_rd == rs_addr[gi]);
      assign rs_val[gi]   = fwd ? wb_data : rf_q[rs_addr[gi]];
      assign wb_hit[gi]   = 1'b0;
`else
      assign rs_val[gi]   = rf_q[rs_addr[gi]];
      assign wb_hit[gi]   = rs_use[gi] && wb_we && (wb_rd != 5'd0) && (wb_rd == rs_addr[gi]);
`endif
      assign lu_hit[gi]   = rs_use[gi] && (id_ex_q.rd == rs_addr[gi]);
   end

   always_comb begin
      dec             = '0;
      rs_use          = 2'b00;
      dec.valid       = 1'b1;
      dec.pc          = if_id_in.pc;
      dec.rs1         = rs_addr[0];
      dec.rs2         = rs_addr[1];
      dec.rd          = rd;
      dec.rs1_val     = rs_val[0];
      dec.rs2_val     = rs_val[1];
      dec.alu_op      = ALU_ADD;
      case (opcode)
         OPC_LUI: begin
            dec.imm         = imm_u;
            dec.alu_op      = ALU_LUI;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm         = imm_u;
            dec.alu_op      = ALU_AUIPC;
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_JAL: begin
            dec.imm         = imm_j;
            dec.alu_src_imm = 1'b1;
            dec.jump        = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_JALR: begin
            rs_use          = 2'b01;
            dec.imm         = imm_i;
            dec.alu_src_imm = 1'b1;
            dec.jump        = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_BRANCH: begin
            rs_use          = 2'b11;
            dec.imm         = imm_b;
            dec.alu_op      = {1'b0, funct3};
            dec.branch      = 1'b1;
         end
         OPC_LOAD: begin
            rs_use          = 2'b01;
            dec.imm         = imm_i;
            dec.alu_src_imm = 1'b1;
            dec.mem_read    = 1'b1;
            dec.mem_size    = funct3;
            dec.reg_write   = 1'b1;
         end
         OPC_STORE: begin
            rs_use          = 2'b11;
            dec.imm         = imm_s;
            dec.alu_src_imm = 1'b1;
            dec.mem_write   = 1'b1;
            dec.mem_size    = funct3;
         end
         OPC_OPIMM: begin
            rs_use          = 2'b01;
            dec.imm         = imm_i;
            dec.alu_op      = {(funct3 == 3'b101) && instr[30], funct3};
            dec.alu_src_imm = 1'b1;
            dec.reg_write   = 1'b1;
         end
         OPC_OP: begin
            rs_use          = 2'b11;
            dec.alu_op      = {instr[30], funct3};
            dec.reg_write   = 1'b1;
         end
         default: begin
            dec.illegal     = 1'b1;
         end
      endcase
      if (rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

   assign load_use  = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) && (|lu_hit);
   assign stall_out = !rst && !flush && if_id_in.valid && (load_use || (|wb_hit));

   // Hazard stalls insert a bubble here while fetch holds the instruction for a retry.
   always_comb begin
      id_ex_d = id_ex_q;
      if (flush) begin
         id_ex_d = '0;
      end else if (stall_in) begin
         id_ex_d = id_ex_q;
      end else if (!if_id_in.valid || stall_out) begin
         id_ex_d = '0;
      end else begin
         id_ex_d = dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign id_ex_out = id_ex_q;

endmodule
